// File: rtl/sr_crypto_seq_pkg.sv
// Shared types and constants for the sr_cpu crypto sequencer.
// State codes, default widths and the rd=x0 write-suppression rule.
package sr_crypto_seq_pkg;

  localparam int CRY_MODE_W  = 21;
  localparam int CRY_TIMEOUT = 64;

  typedef enum logic [1:0] {
    CRY_ST_IDLE  = 2'd0,
    CRY_ST_ISSUE = 2'd1,
    CRY_ST_WAIT  = 2'd2,
    CRY_ST_WB    = 2'd3
  } cry_state_e;

  // Writes to x0 are architecturally discarded, so the enable is suppressed.
  function automatic logic rf_write_allowed(input logic [4:0] rd);
    return (rd != 5'd0);
  endfunction

endpackage

// File: rtl/sr_crypto_seq_if.sv
// Request/response bus between the crypto sequencer (master) and the crypto unit (slave).
interface sr_crypto_seq_if
  import sr_crypto_seq_pkg::*;
#(
  parameter int MODE_W = CRY_MODE_W
);

  logic              cry_i_valid;
  logic              cry_i_ready;
  logic [31:0]       cry_i_a;
  logic [31:0]       cry_i_b;
  logic [MODE_W-1:0] cry_i_mode;
  logic              cry_o_valid;
  logic [31:0]       cry_o_data;

  modport master (
    output cry_i_valid,
    output cry_i_a,
    output cry_i_b,
    output cry_i_mode,
    input  cry_i_ready,
    input  cry_o_valid,
    input  cry_o_data
  );

  modport slave (
    input  cry_i_valid,
    input  cry_i_a,
    input  cry_i_b,
    input  cry_i_mode,
    output cry_i_ready,
    output cry_o_valid,
    output cry_o_data
  );

endinterface

// File: rtl/sr_crypto_wdt.sv
// 8-bit watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module sr_crypto_wdt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/sr_crypto_seq.sv
// Multi-cycle sequencer between sr_cpu and the crypto unit: stalls the core, issues one
// request, waits (watchdog-bounded) for the result and performs a single rf write.
module sr_crypto_seq
  import sr_crypto_seq_pkg::*;
#(
  parameter int MODE_W  = CRY_MODE_W,
  parameter int TIMEOUT = CRY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cryInstr,
  input  logic [MODE_W-1:0] cryMode,
  input  logic [4:0]        cryRd,
  input  logic [31:0]       cryA,
  input  logic [31:0]       cryB,
  sr_crypto_seq_if.master   cry,
  output logic              hold,
  output logic              ctrlSelect,
  output logic              rfWe,
  output logic [4:0]        rfWa,
  output logic [31:0]       rfWd,
  output logic              busy,
  output logic              err
);

  cry_state_e        state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;

  logic wdt_clr;
  logic wdt_en;
  logic wdt_expired;

  // Counter restarts on every WAIT entry and only advances while no result has arrived.
  assign wdt_clr = (state_q != CRY_ST_WAIT);
  assign wdt_en  = (state_q == CRY_ST_WAIT) && !cry.cry_o_valid;

  sr_crypto_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wdt_clr),
    .en     (wdt_en),
    .expired(wdt_expired)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      CRY_ST_IDLE: begin
        if (cryInstr) begin
          a_d     = cryA;
          b_d     = cryB;
          mode_d  = cryMode;
          rd_d    = cryRd;
          state_d = CRY_ST_ISSUE;
        end
      end
      CRY_ST_ISSUE: begin
        if (cry.cry_i_ready) begin
          state_d = CRY_ST_WAIT;
        end
      end
      CRY_ST_WAIT: begin
        // A result arriving on the expiry cycle still counts as a success.
        if (cry.cry_o_valid) begin
          result_d = cry.cry_o_data;
          state_d  = CRY_ST_WB;
        end else if (wdt_expired) begin
          result_d = 32'd0;
          err_d    = 1'b1;
          state_d  = CRY_ST_WB;
        end
      end
      CRY_ST_WB: begin
        state_d = CRY_ST_IDLE;
      end
      default: begin
        state_d = CRY_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CRY_ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mode_q   <= '0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  logic        hold_c;
  logic        ctrl_c;
  logic        valid_c;
  logic        we_c;
  logic [4:0]  wa_c;
  logic [31:0] wd_c;

  // hold drops in WB so the core advances its PC on the same edge as the rf write.
  always_comb begin
    hold_c  = 1'b0;
    ctrl_c  = 1'b0;
    valid_c = 1'b0;
    we_c    = 1'b0;
    wa_c    = 5'd0;
    wd_c    = 32'd0;

    unique case (state_q)
      CRY_ST_IDLE: begin
        hold_c = cryInstr;
      end
      CRY_ST_ISSUE: begin
        hold_c  = 1'b1;
        ctrl_c  = 1'b1;
        valid_c = 1'b1;
      end
      CRY_ST_WAIT: begin
        hold_c = 1'b1;
        ctrl_c = 1'b1;
      end
      CRY_ST_WB: begin
        ctrl_c = 1'b1;
        we_c   = rf_write_allowed(rd_q);
        wa_c   = rd_q;
        wd_c   = result_q;
      end
      default: begin
        hold_c = 1'b0;
      end
    endcase
  end

  // Every output is forced low while reset is asserted, even before the first edge.
  assign hold            = rst_n & hold_c;
  assign ctrlSelect      = rst_n & ctrl_c;
  assign rfWe            = rst_n & we_c;
  assign rfWa            = rst_n ? wa_c : 5'd0;
  assign rfWd            = rst_n ? wd_c : 32'd0;
  assign busy            = rst_n & (state_q != CRY_ST_IDLE);
  assign err             = rst_n & err_q;
  assign cry.cry_i_valid = rst_n & valid_c;
  assign cry.cry_i_a     = rst_n ? a_q : 32'd0;
  assign cry.cry_i_b     = rst_n ? b_q : 32'd0;
  assign cry.cry_i_mode  = rst_n ? mode_q : '0;

endmodule

// File: tb/tb_sr_crypto_seq.sv
// Scoreboard bench for sr_crypto_seq: stimulus pushes expected issues and rf writes,
// an independent monitor pops and compares them when the DUT presents them.
module tb_sr_crypto_seq;
  import sr_crypto_seq_pkg::*;

  localparam int TMO = 8;

  typedef struct {
    logic [31:0]           a;
    logic [31:0]           b;
    logic [CRY_MODE_W-1:0] mode;
  } issue_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
  } wb_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cryInstr = 1'b0;
  logic [CRY_MODE_W-1:0] cryMode = '0;
  logic [4:0]            cryRd = 5'd0;
  logic [31:0]           cryA = 32'd0;
  logic [31:0]           cryB = 32'd0;
  logic                  hold, ctrlSelect, rfWe, busy, err;
  logic [4:0]            rfWa;
  logic [31:0]           rfWd;

  sr_crypto_seq_if #(.MODE_W(CRY_MODE_W)) cry_bus ();

  sr_crypto_seq #(
    .MODE_W (CRY_MODE_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cryInstr  (cryInstr),
    .cryMode   (cryMode),
    .cryRd     (cryRd),
    .cryA      (cryA),
    .cryB      (cryB),
    .cry       (cry_bus),
    .hold      (hold),
    .ctrlSelect(ctrlSelect),
    .rfWe      (rfWe),
    .rfWa      (rfWa),
    .rfWd      (rfWd),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  issue_t issueQ[$];
  wb_t    wbQ[$];
  int     nCmp = 0;
  int     nErr = 0;
  bit     errModel = 1'b0;
  issue_t monIssue;
  wb_t    monWb;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT hands over a request or writes back.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cry_bus.cry_i_valid && cry_bus.cry_i_ready) begin
        if (issueQ.size() == 0) begin
          checkOutput("unexpected_issue", 64'd1, 64'd0);
        end else begin
          monIssue = issueQ.pop_front();
          checkOutput("issue_a", 64'(cry_bus.cry_i_a), 64'(monIssue.a));
          checkOutput("issue_b", 64'(cry_bus.cry_i_b), 64'(monIssue.b));
          checkOutput("issue_mode", 64'(cry_bus.cry_i_mode), 64'(monIssue.mode));
        end
      end
      if (ctrlSelect && !hold) begin
        if (wbQ.size() == 0) begin
          checkOutput("unexpected_wb", 64'd1, 64'd0);
        end else begin
          monWb = wbQ.pop_front();
          checkOutput("wb_we", 64'(rfWe), 64'(monWb.we));
          checkOutput("wb_wa", 64'(rfWa), 64'(monWb.wa));
          checkOutput("wb_wd", 64'(rfWd), 64'(monWb.wd));
          checkOutput("wb_err", 64'(err), 64'(monWb.err));
        end
      end else begin
        checkOutput("rf_quiet", 64'({rfWe, rfWa, rfWd}), 64'd0);
      end
    end
  end

  // One complete crypto instruction; vldDly==0 means the unit never answers.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [CRY_MODE_W-1:0] mode, input logic [4:0] rd,
                               input int rdyDly, input int vldDly, input logic [31:0] data);
    issue_t ei;
    wb_t    ew;
    bit     tmo;
    int     waitCycles;
    tmo        = (vldDly == 0);
    waitCycles = tmo ? TMO : vldDly;
    ei.a = a; ei.b = b; ei.mode = mode;
    issueQ.push_back(ei);
    if (tmo) errModel = 1'b1;
    ew.we  = (rd != 5'd0);
    ew.wa  = rd;
    ew.wd  = tmo ? 32'd0 : data;
    ew.err = errModel;
    wbQ.push_back(ew);

    cryInstr = 1'b1; cryA = a; cryB = b; cryMode = mode; cryRd = rd;
    @(negedge clk);
    checkOutput("idle_hold_busy", 64'({hold, busy, ctrlSelect}), 64'b100);
    @(posedge clk); #1;
    for (int k = 0; k <= rdyDly; k++) begin
      cryA = $urandom; cryB = $urandom; cryMode = CRY_MODE_W'($urandom); cryRd = 5'($urandom);
      cry_bus.cry_i_ready = (k == rdyDly);
      @(negedge clk);
      checkOutput("issue_ctl", 64'({cry_bus.cry_i_valid, hold, ctrlSelect, busy}), 64'b1111);
      checkOutput("issue_a_stable", 64'(cry_bus.cry_i_a), 64'(a));
      checkOutput("issue_b_stable", 64'(cry_bus.cry_i_b), 64'(b));
      checkOutput("issue_mode_stable", 64'(cry_bus.cry_i_mode), 64'(mode));
      @(posedge clk); #1;
    end
    cry_bus.cry_i_ready = 1'b0;
    for (int k = 1; k <= waitCycles; k++) begin
      cry_bus.cry_o_valid = !tmo && (k == vldDly);
      cry_bus.cry_o_data  = (!tmo && (k == vldDly)) ? data : $urandom;
      @(negedge clk);
      checkOutput("wait_ctl", 64'({cry_bus.cry_i_valid, hold, ctrlSelect, busy}), 64'b0111);
      @(posedge clk); #1;
    end
    cry_bus.cry_o_valid = 1'b0;
    @(negedge clk);
    checkOutput("wb_timing", 64'({hold, ctrlSelect, busy}), 64'b011);
    @(posedge clk); #1;
    cryInstr = 1'b0;
  endtask

  task automatic checkIdle();
    @(negedge clk);
    checkOutput("idle", 64'({busy, hold, ctrlSelect, cry_bus.cry_i_valid}), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic randomOps(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus($urandom, $urandom, CRY_MODE_W'($urandom), 5'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, TMO)), $urandom);
      checkIdle();
    end
  endtask

  initial begin
    cry_bus.cry_i_ready = 1'b0;
    cry_bus.cry_o_valid = 1'b0;
    cry_bus.cry_o_data  = 32'd0;

    rst_n = 1'b0; cryInstr = 1'b1;
    @(negedge clk);
    checkOutput("reset_outs", 64'({hold, cry_bus.cry_i_valid, rfWe, busy, err, ctrlSelect}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_outs2", 64'({hold, cry_bus.cry_i_valid, rfWe, busy, err, ctrlSelect}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cryInstr = 1'b0;
    checkIdle();

    applyStimulus(32'h01234567, 32'h89ABCDEF, 21'h00001, 5'd5, 0, 1, 32'hDEADBEEF);
    checkIdle();
    applyStimulus(32'hCAFEF00D, 32'h13579BDF, 21'h12345, 5'd9, 3, 5, 32'hA5A5_0F0F);
    checkIdle();
    applyStimulus(32'h11112222, 32'h33334444, 21'h00400, 5'd0, 1, 2, 32'h55AA55AA);
    checkIdle();
    applyStimulus(32'h0BAD0BAD, 32'h600D600D, 21'h1FFFFF, 5'd31, 0, TMO, 32'h7777_8888);
    checkIdle();
    randomOps(4);

    applyStimulus(32'h0F0F0F0F, 32'hF0F0F0F0, 21'h00002, 5'd7, 1, 0, 32'h0);
    cry_bus.cry_o_valid = 1'b1; cry_bus.cry_o_data = 32'h12345678;
    checkIdle();
    cry_bus.cry_o_valid = 1'b0;
    checkIdle();
    randomOps(3);

    monIssue.a = 32'hAAAA0001; monIssue.b = 32'hBBBB0002; monIssue.mode = 21'h00010;
    issueQ.push_back(monIssue);
    cryInstr = 1'b1; cryA = 32'hAAAA0001; cryB = 32'hBBBB0002; cryMode = 21'h00010; cryRd = 5'd3;
    @(posedge clk); #1;
    cry_bus.cry_i_ready = 1'b1;
    @(posedge clk); #1;
    cry_bus.cry_i_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wait", 64'({hold, ctrlSelect, busy, rfWe, cry_bus.cry_i_valid}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cryInstr = 1'b0; errModel = 1'b0;
    @(negedge clk);
    checkOutput("after_rst", 64'({busy, err}), 64'd0);
    @(posedge clk); #1;

    applyStimulus(32'h10203040, 32'h50607080, 21'h00100, 5'd12, 0, 1, 32'hFEEDFACE);
    applyStimulus(32'h90A0B0C0, 32'hD0E0F000, 21'h00200, 5'd13, 0, 1, 32'hBEEF1234);
    checkIdle();
    randomOps(3);

    repeat (2) @(posedge clk);
    checkOutput("issueQ_empty", 64'(issueQ.size()), 64'd0);
    checkOutput("wbQ_empty", 64'(wbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
